spi_cmd_sequencer: RTL and testbench

- Frame-level controller behind the SPI byte receiver.
- Consumes received bytes (Buffer/Changed pair, LSB-first SPI, CS high = deselect) and decodes a command frame: command byte, address byte, then data/dummy bytes.
- Sequences single-beat transactions on an internal register bus with address auto-increment.
- Supplies read data to the SPI transmit side.

---
 rtl/spi_cmd_sequencer_pkg.sv | 19 +
 rtl/spi_cmd_sequencer_reg_req_port.sv | 57 +++++
 rtl/spi_cmd_sequencer.sv | 129 ++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types and default opcodes for the SPI command-frame sequencer.
// The state enum is shared so the sub-module and any future debug logic agree on encoding.
package spi_cmd_sequencer_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WRITE,
        ST_READ,
        ST_DISCARD
    } state_t;

    localparam byte_t CMD_WRITE_DEFAULT = 8'h01;
    localparam byte_t CMD_READ_DEFAULT  = 8'h02;

endpackage

// File: rtl/spi_cmd_sequencer_reg_req_port.sv
// Register-bus request port: holds a single-beat request until acknowledged,
// owns the auto-incrementing address counter and returns read data to the SPI transmit side.
module spi_reg_req_port
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              issue,
    input  logic              issue_we,
    input  byte_t             issue_wdata,
    input  logic              reg_ack,
    input  byte_t             reg_rdata,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output byte_t             reg_wdata,
    output byte_t             tx_byte,
    output logic              tx_load
);

    // The address counter doubles as the bus address, so it must only move on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_req   <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            tx_byte   <= 8'h00;
            tx_load   <= 1'b0;
        end else begin
            tx_load <= 1'b0;
            if (load_addr) begin
                reg_addr <= addr_in;
            end else if (reg_req && reg_ack) begin
                reg_addr <= reg_addr + ADDR_W'(1);
            end
            if (reg_req && reg_ack) begin
                reg_req <= 1'b0;
                if (!reg_we) begin
                    tx_byte <= reg_rdata;
                    tx_load <= 1'b1;
                end
            end else if (issue && !reg_req) begin
                reg_req <= 1'b1;
                reg_we  <= issue_we;
                if (issue_we) begin
                    reg_wdata <= issue_wdata;
                end
            end
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Frame-level SPI command decoder: command byte, address byte, then write data or read dummies,
// turned into single-beat register-bus transactions with address auto-increment.
module spi_cmd_sequencer
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int    ADDR_W    = 8,
    parameter byte_t CMD_WRITE = CMD_WRITE_DEFAULT,
    parameter byte_t CMD_READ  = CMD_READ_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  byte_t             byte_in,
    input  logic              byte_valid,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output byte_t             reg_wdata,
    input  logic              reg_ack,
    input  byte_t             reg_rdata,
    output byte_t             tx_byte,
    output logic              tx_load,
    input  logic              clr_err,
    output logic              err_badcmd,
    output logic              err_overrun,
    output logic              busy
);

    state_t state, state_nx;
    logic   mode_rd, mode_rd_nx;
    logic   load_addr, issue, issue_we;
    logic   set_badcmd, set_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mode_rd     <= 1'b0;
            err_badcmd  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nx;
            mode_rd     <= mode_rd_nx;
            err_badcmd  <= set_badcmd  ? 1'b1 : (clr_err ? 1'b0 : err_badcmd);
            err_overrun <= set_overrun ? 1'b1 : (clr_err ? 1'b0 : err_overrun);
        end
    end

    // Deselect wins over everything, including a byte landing in the same cycle.
    always_comb begin
        state_nx    = state;
        mode_rd_nx  = mode_rd;
        load_addr   = 1'b0;
        issue       = 1'b0;
        issue_we    = 1'b0;
        set_badcmd  = 1'b0;
        set_overrun = 1'b0;
        if (state != ST_IDLE && cs) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!cs && !reg_req) state_nx = ST_CMD;
                end
                ST_CMD: begin
                    if (byte_valid) begin
                        if (byte_in == CMD_WRITE) begin
                            state_nx   = ST_ADDR;
                            mode_rd_nx = 1'b0;
                        end else if (byte_in == CMD_READ) begin
                            state_nx   = ST_ADDR;
                            mode_rd_nx = 1'b1;
                        end else begin
                            set_badcmd = 1'b1;
                            state_nx   = ST_DISCARD;
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_valid) begin
                        load_addr = 1'b1;
                        if (mode_rd) begin
                            state_nx = ST_READ;
                            issue    = 1'b1;
                        end else begin
                            state_nx = ST_WRITE;
                        end
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (byte_valid) begin
                        if (reg_req) begin
                            set_overrun = 1'b1;
                            state_nx    = ST_DISCARD;
                        end else begin
                            issue    = 1'b1;
                            issue_we = (state == ST_WRITE);
                        end
                    end
                end
                ST_DISCARD: begin
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE) || reg_req;

    spi_reg_req_port #(
        .ADDR_W(ADDR_W)
    ) u_req_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_addr  (load_addr),
        .addr_in    (byte_in[ADDR_W-1:0]),
        .issue      (issue),
        .issue_we   (issue_we),
        .issue_wdata(byte_in),
        .reg_ack    (reg_ack),
        .reg_rdata  (reg_rdata),
        .reg_req    (reg_req),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .tx_byte    (tx_byte),
        .tx_load    (tx_load)
    );

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: a frame-level model predicts bus transactions and
// TX bytes into queues; a monitor pops and compares them as the DUT completes handshakes.
module tb_spi_cmd_sequencer;
    import spi_cmd_sequencer_pkg::*;

    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        rst_n, cs, byte_valid, reg_ack, clr_err;
    byte_t       byte_in, reg_rdata;
    logic        reg_req, reg_we, tx_load, err_badcmd, err_overrun, busy;
    logic [ADDR_W-1:0] reg_addr;
    byte_t       reg_wdata, tx_byte;

    always #5 clk = ~clk;

    spi_cmd_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .byte_in(byte_in), .byte_valid(byte_valid),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata), .tx_byte(tx_byte), .tx_load(tx_load),
        .clr_err(clr_err), .err_badcmd(err_badcmd), .err_overrun(err_overrun), .busy(busy)
    );

    typedef struct {
        logic  we;
        byte_t addr;
        byte_t wdata;
    } txn_t;

    txn_t  exp_txn_q[$];
    byte_t exp_tx_q[$];
    byte_t frame_q[$];
    byte_t model_mem[256];
    byte_t resp_mem[256];
    int    checks = 0;
    int    failures = 0;
    int    ack_delay = -1;
    int    ack_cnt = 0;
    bit    exp_bad;

    task automatic check_value(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pick_delay();
        return (ack_delay < 0) ? int'($urandom_range(3, 0)) : ack_delay;
    endfunction

    // Bus slave with its own register file; ack latency counted from the request rise.
    initial begin
        reg_ack   = 1'b0;
        reg_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reg_ack) begin
                reg_ack = 1'b0;
                ack_cnt = pick_delay();
            end else if (reg_req && rst_n) begin
                if (ack_cnt == 0) begin
                    reg_ack   = 1'b1;
                    reg_rdata = resp_mem[reg_addr];
                    if (reg_we) resp_mem[reg_addr] = reg_wdata;
                end else begin
                    ack_cnt--;
                end
            end else begin
                ack_cnt = pick_delay();
            end
        end
    end

    initial begin
        txn_t  t;
        byte_t b;
        forever begin
            @(negedge clk);
            #2;
            if (reg_req && reg_ack) begin
                if (exp_txn_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_txn actual=we%0d@%0h required=none", reg_we, reg_addr);
                end else begin
                    t = exp_txn_q.pop_front();
                    check_value("txn_we", 32'(reg_we), 32'(t.we));
                    check_value("txn_addr", 32'(reg_addr), 32'(t.addr));
                    if (t.we) check_value("txn_wdata", 32'(reg_wdata), 32'(t.wdata));
                end
            end
            if (tx_load) begin
                if (exp_tx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_tx_load actual=%0h required=none", tx_byte);
                end else begin
                    b = exp_tx_q.pop_front();
                    check_value("tx_byte", 32'(tx_byte), 32'(b));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic build(int n, byte_t b0, byte_t b1 = 0, byte_t b2 = 0, byte_t b3 = 0);
        byte_t tmp[4];
        tmp = '{b0, b1, b2, b3};
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(tmp[i]);
    endtask

    // Frame semantics: opcode, start address, then one transfer per byte (reads also one at the address byte).
    task automatic model_frame();
        byte_t a;
        exp_bad = 1'b0;
        if (frame_q.size() == 0) return;
        if (frame_q[0] == 8'h01) begin
            if (frame_q.size() < 2) return;
            a = frame_q[1];
            for (int i = 2; i < frame_q.size(); i++) begin
                exp_txn_q.push_back('{we: 1'b1, addr: a, wdata: frame_q[i]});
                model_mem[a] = frame_q[i];
                a = a + 8'd1;
            end
        end else if (frame_q[0] == 8'h02) begin
            if (frame_q.size() < 2) return;
            a = frame_q[1];
            for (int i = 1; i < frame_q.size(); i++) begin
                exp_txn_q.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
                exp_tx_q.push_back(model_mem[a]);
                a = a + 8'd1;
            end
        end else begin
            exp_bad = 1'b1;
        end
    endtask

    task automatic send_byte(byte_t b, int gap);
        @(posedge clk);
        #1;
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic cs_low();
        @(posedge clk);
        #1 cs = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_req_low(string name);
        int n = 0;
        while (reg_req && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_value(name, 32'(reg_req), 32'd0);
    endtask

    task automatic wait_busy_low(string name);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_value(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_idle(string name);
        @(posedge clk);
        #1 cs = 1'b1;
        wait_busy_low(name);
    endtask

    task automatic apply_stimulus(int gap);
        model_frame();
        cs_low();
        foreach (frame_q[i]) send_byte(frame_q[i], gap);
        wait_req_low("frame_req_done");
        wait_idle("frame_idle");
    endtask

    task automatic check_output(string name, bit bad, bit ovr);
        check_value({name, "_badcmd"}, 32'(err_badcmd), 32'(bad));
        check_value({name, "_overrun"}, 32'(err_overrun), 32'(ovr));
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    initial begin
        byte_t op;
        int    len;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'(i + 3);
            resp_mem[i]  = 8'(i + 3);
        end
        rst_n = 1'b0; cs = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; clr_err = 1'b0;

        repeat (2) @(negedge clk);
        check_value("rst_req", 32'(reg_req), 32'd0);
        check_value("rst_we", 32'(reg_we), 32'd0);
        check_value("rst_addr", 32'(reg_addr), 32'd0);
        check_value("rst_wdata", 32'(reg_wdata), 32'd0);
        check_value("rst_tx_byte", 32'(tx_byte), 32'd0);
        check_value("rst_tx_load", 32'(tx_load), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_output("rst", 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write burst, then a byte coinciding with CS rising must be dropped.
        ack_delay = 1;
        build(4, 8'h01, 8'h10, 8'hAA, 8'h55);
        model_frame();
        cs_low();
        foreach (frame_q[i]) send_byte(frame_q[i], 4);
        wait_req_low("wr_req_done");
        @(posedge clk);
        #1;
        byte_in = 8'hEE; byte_valid = 1'b1; cs = 1'b1;
        @(posedge clk);
        #1 byte_valid = 1'b0;
        wait_busy_low("wr_idle");
        check_output("wr", 1'b0, 1'b0);

        // Read burst across the address wrap.
        ack_delay = -1;
        build(4, 8'h02, 8'hFE, 8'h00, 8'h00);
        apply_stimulus(7);
        check_output("rd", 1'b0, 1'b0);

        // Unknown opcode; later bytes must not reach the bus.
        build(4, 8'h7F, 8'h10, 8'h20, 8'h30);
        apply_stimulus(5);
        check_output("bad", 1'b1, 1'b0);
        pulse_clr();
        check_output("bad_clr", 1'b0, 1'b0);

        // Error set beats a simultaneous clear.
        cs_low();
        @(posedge clk);
        #1 byte_in = 8'h7F; byte_valid = 1'b1; clr_err = 1'b1;
        @(posedge clk);
        #1 byte_valid = 1'b0; clr_err = 1'b0;
        check_value("set_over_clr", 32'(err_badcmd), 32'd1);
        wait_idle("setclr_idle");
        pulse_clr();

        // Overrun while a slow write is pending.
        ack_delay = 20;
        exp_txn_q.push_back('{we: 1'b1, addr: 8'h40, wdata: 8'h11});
        model_mem[8'h40] = 8'h11;
        cs_low();
        send_byte(8'h01, 3);
        send_byte(8'h40, 3);
        send_byte(8'h11, 2);
        send_byte(8'h22, 2);
        check_value("ovr_flag", 32'(err_overrun), 32'd1);
        check_value("ovr_req_held", 32'(reg_req), 32'd1);
        send_byte(8'h33, 2);
        wait_req_low("ovr_req_done");
        send_byte(8'h44, 4);
        check_value("ovr_discard_busy", 32'(busy), 32'd1);
        wait_idle("ovr_idle");
        check_output("ovr", 1'b0, 1'b1);
        pulse_clr();

        // CS rises with a write outstanding: the request survives until ack.
        exp_txn_q.push_back('{we: 1'b1, addr: 8'h20, wdata: 8'h99});
        model_mem[8'h20] = 8'h99;
        cs_low();
        send_byte(8'h01, 3);
        send_byte(8'h20, 3);
        send_byte(8'h99, 1);
        @(posedge clk);
        #1 cs = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_value("cs_req_held", 32'(reg_req), 32'd1);
        check_value("cs_busy", 32'(busy), 32'd1);
        wait_busy_low("cs_idle");
        ack_delay = -1;
        build(3, 8'h01, 8'h30, 8'h77);
        apply_stimulus(7);

        // Asynchronous reset in the middle of a read.
        ack_delay = 20;
        cs_low();
        send_byte(8'h02, 3);
        send_byte(8'h05, 3);
        check_value("mid_rd_req", 32'(reg_req), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_value("arst_req", 32'(reg_req), 32'd0);
        check_value("arst_addr", 32'(reg_addr), 32'd0);
        check_value("arst_tx_byte", 32'(tx_byte), 32'd0);
        check_value("arst_busy", 32'(busy), 32'd0);
        cs = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_delay = -1;
        build(3, 8'h02, 8'h05, 8'h00);
        apply_stimulus(7);
        check_output("post_rst", 1'b0, 1'b0);

        // Randomized frames with spacing that never overruns.
        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(4, 1));
            if ($urandom_range(9, 0) == 0) op = 8'h80 | 8'($urandom_range(127, 0));
            else op = ($urandom_range(1, 0) == 0) ? 8'h01 : 8'h02;
            frame_q.delete();
            frame_q.push_back(op);
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom_range(255, 0)));
            apply_stimulus(7);
            check_output("rand", exp_bad, 1'b0);
            if (exp_bad) pulse_clr();
        end

        repeat (5) @(posedge clk);
        check_value("txn_queue_empty", 32'(exp_txn_q.size()), 32'd0);
        check_value("tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
